l1d_amo_unit: RTL and testbench

L1D_AMO_UNIT -- requirements
Module: l1d_amo_unit

---
 rtl/uop_encoding_pkg.sv | 86 ++++++++
 rtl/l1d_amo_alu.sv | 44 ++++
 rtl/l1d_amo_unit.sv | 201 ++++++++++++++++++++
 tb/tb_l1d_amo_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uop_encoding_pkg.sv
// rtl/uop_encoding_pkg.sv - store-unit minor op encoding plus AMO unit state and function enums
// Atomic ops occupy one contiguous block; within it each W op is even and its D twin is odd.
package uop_encoding_pkg;

  localparam int STU_OP_WIDTH = 6;

  typedef enum logic [STU_OP_WIDTH-1:0] {
    STU_NOP      = 6'h00,
    STU_LD       = 6'h01,
    STU_SD       = 6'h02,
    STU_LRW      = 6'h08,
    STU_LRD      = 6'h09,
    STU_SCW      = 6'h0A,
    STU_SCD      = 6'h0B,
    STU_AMOSWAPW = 6'h0C,
    STU_AMOSWAPD = 6'h0D,
    STU_AMOADDW  = 6'h0E,
    STU_AMOADDD  = 6'h0F,
    STU_AMOANDW  = 6'h10,
    STU_AMOANDD  = 6'h11,
    STU_AMOORW   = 6'h12,
    STU_AMOORD   = 6'h13,
    STU_AMOXORW  = 6'h14,
    STU_AMOXORD  = 6'h15,
    STU_AMOMAXW  = 6'h16,
    STU_AMOMAXD  = 6'h17,
    STU_AMOMAXUW = 6'h18,
    STU_AMOMAXUD = 6'h19,
    STU_AMOMINW  = 6'h1A,
    STU_AMOMIND  = 6'h1B,
    STU_AMOMINUW = 6'h1C,
    STU_AMOMINUD = 6'h1D,
    STU_FENCE    = 6'h20
  } stu_minor_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_RESP
  } amo_state_t;

  typedef enum logic [3:0] {
    AMO_SWAP,
    AMO_ADD,
    AMO_AND,
    AMO_OR,
    AMO_XOR,
    AMO_MAX,
    AMO_MAXU,
    AMO_MIN,
    AMO_MINU
  } amo_func_t;

  function automatic logic op_is_amo(stu_minor_op_t op);
    return (op >= STU_LRW) && (op <= STU_AMOMINUD);
  endfunction

  function automatic logic op_is_word(stu_minor_op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_lr(stu_minor_op_t op);
    return (op == STU_LRW) || (op == STU_LRD);
  endfunction

  function automatic logic op_is_sc(stu_minor_op_t op);
    return (op == STU_SCW) || (op == STU_SCD);
  endfunction

  function automatic amo_func_t amo_func_of(stu_minor_op_t op);
    case (op)
      STU_AMOADDW,  STU_AMOADDD:  return AMO_ADD;
      STU_AMOANDW,  STU_AMOANDD:  return AMO_AND;
      STU_AMOORW,   STU_AMOORD:   return AMO_OR;
      STU_AMOXORW,  STU_AMOXORD:  return AMO_XOR;
      STU_AMOMAXW,  STU_AMOMAXD:  return AMO_MAX;
      STU_AMOMAXUW, STU_AMOMAXUD: return AMO_MAXU;
      STU_AMOMINW,  STU_AMOMIND:  return AMO_MIN;
      STU_AMOMINUW, STU_AMOMINUD: return AMO_MINU;
      default:                    return AMO_SWAP;
    endcase
  endfunction

endpackage

// File: rtl/l1d_amo_alu.sv
// rtl/l1d_amo_alu.sv - combinational read-modify-write function for atomic memory ops
// Word results are replicated across the doubleword so the byte mask alone picks the lane.
module l1d_amo_alu
  import uop_encoding_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  amo_func_t        op,
  input  logic [XLEN-1:0]  old,
  input  logic [XLEN-1:0]  operand,
  input  logic             is_word,
  output logic [XLEN-1:0]  new_data
);

  logic [31:0]     old_w;
  logic [31:0]     opd_w;
  logic [31:0]     res_w;
  logic [XLEN-1:0] res_d;
  logic            lt_s_w, lt_u_w, lt_s_d, lt_u_d;

  always_comb begin
    old_w  = old[31:0];
    opd_w  = operand[31:0];
    lt_s_w = $signed(old_w) < $signed(opd_w);
    lt_u_w = old_w < opd_w;
    lt_s_d = $signed(old) < $signed(operand);
    lt_u_d = old < operand;
    res_w  = opd_w;
    res_d  = operand;
    case (op)
      AMO_ADD:  begin res_w = old_w + opd_w;            res_d = old + operand;            end
      AMO_AND:  begin res_w = old_w & opd_w;            res_d = old & operand;            end
      AMO_OR:   begin res_w = old_w | opd_w;            res_d = old | operand;            end
      AMO_XOR:  begin res_w = old_w ^ opd_w;            res_d = old ^ operand;            end
      AMO_MAX:  begin res_w = lt_s_w ? opd_w : old_w;   res_d = lt_s_d ? operand : old;   end
      AMO_MAXU: begin res_w = lt_u_w ? opd_w : old_w;   res_d = lt_u_d ? operand : old;   end
      AMO_MIN:  begin res_w = lt_s_w ? old_w : opd_w;   res_d = lt_s_d ? old : operand;   end
      AMO_MINU: begin res_w = lt_u_w ? old_w : opd_w;   res_d = lt_u_d ? old : operand;   end
      default:  begin res_w = opd_w;                    res_d = operand;                  end
    endcase
    new_data = is_word ? {(XLEN/32){res_w}} : res_d;
  end

endmodule

// File: rtl/l1d_amo_unit.sv
// rtl/l1d_amo_unit.sv - L1D atomic unit: LR/SC reservation and AMO read-modify-write sequencing
// One request in flight; reads and writes go to the cache as aligned doublewords.
module l1d_amo_unit
  import uop_encoding_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int PADDR_W    = 56,
  parameter int ID_W       = 4,
  parameter int LINE_OFF_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_vld,
  output logic                req_rdy,
  input  stu_minor_op_t       req_op,
  input  logic [PADDR_W-1:0]  req_addr,
  input  logic [XLEN-1:0]     req_data,
  input  logic [ID_W-1:0]     req_id,
  output logic                rd_vld,
  input  logic                rd_rdy,
  output logic [PADDR_W-1:0]  rd_addr,
  input  logic                rd_resp_vld,
  input  logic [XLEN-1:0]     rd_resp_data,
  output logic                wr_vld,
  input  logic                wr_rdy,
  output logic [PADDR_W-1:0]  wr_addr,
  output logic [XLEN-1:0]     wr_data,
  output logic [XLEN/8-1:0]   wr_mask,
  output logic                resp_vld,
  input  logic                resp_rdy,
  output logic [ID_W-1:0]     resp_id,
  output logic [XLEN-1:0]     resp_data,
  output logic                resp_err,
  input  logic                inv_vld,
  input  logic [PADDR_W-1:0]  inv_addr
);

  localparam int LINE_W = PADDR_W - LINE_OFF_W;
  localparam int MASK_W = XLEN / 8;

  amo_state_t         state_q, state_d;
  stu_minor_op_t      op_q, op_d;
  logic [PADDR_W-1:2] addr_q, addr_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [XLEN-1:0]    wr_data_q, wr_data_d;
  logic [MASK_W-1:0]  wr_mask_q, wr_mask_d;
  logic [XLEN-1:0]    resp_data_q, resp_data_d;
  logic               resp_err_q, resp_err_d;
  logic               resv_vld_q, resv_vld_d;
  logic [LINE_W-1:0]  resv_line_q, resv_line_d;

  logic [LINE_W-1:0]  req_line, cur_line, inv_line;
  logic               misaligned, sc_ok;
  logic [31:0]        old_word;
  logic [XLEN-1:0]    old_ext, alu_operand, alu_new;
  amo_func_t          alu_func;
  logic               alu_is_word;

  function automatic logic [MASK_W-1:0] lane_mask(logic word, logic upper);
    if (!word) return '1;
    return upper ? MASK_W'(8'hF0) : MASK_W'(8'h0F);
  endfunction

  assign req_line   = req_addr[PADDR_W-1:LINE_OFF_W];
  assign cur_line   = addr_q[PADDR_W-1:LINE_OFF_W];
  assign inv_line   = LINE_W'(inv_addr >> LINE_OFF_W);
  assign misaligned = op_is_word(req_op) ? (req_addr[1:0] != 2'b00) : (req_addr[2:0] != 3'b000);

  // In IDLE the ALU only forwards SC store data; afterwards it does the AMO on returned data.
  assign old_word    = rd_resp_data[{addr_q[2], 5'd0} +: 32];
  assign old_ext     = op_is_word(op_q) ? {{(XLEN-32){old_word[31]}}, old_word} : rd_resp_data;
  assign alu_func    = (state_q == ST_IDLE) ? AMO_SWAP : amo_func_of(op_q);
  assign alu_operand = (state_q == ST_IDLE) ? req_data : data_q;
  assign alu_is_word = op_is_word((state_q == ST_IDLE) ? req_op : op_q);

  l1d_amo_alu #(.XLEN(XLEN)) u_alu (
    .op       (alu_func),
    .old      (old_ext),
    .operand  (alu_operand),
    .is_word  (alu_is_word),
    .new_data (alu_new)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    id_d        = id_q;
    wr_data_d   = wr_data_q;
    wr_mask_d   = wr_mask_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    resv_vld_d  = resv_vld_q;
    resv_line_d = resv_line_q;
    sc_ok       = 1'b0;

    if (inv_vld && resv_vld_q && (inv_line == resv_line_q)) begin
      resv_vld_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_vld) begin
          op_d        = req_op;
          addr_d      = req_addr[PADDR_W-1:2];
          data_d      = req_data;
          id_d        = req_id;
          resp_err_d  = 1'b0;
          resp_data_d = '0;
          if (!op_is_amo(req_op) || misaligned) begin
            resp_err_d = 1'b1;
            state_d    = ST_RESP;
          end else if (op_is_sc(req_op)) begin
            // A snoop to the reserved line in this same cycle must beat the SC.
            sc_ok = resv_vld_q && (resv_line_q == req_line) &&
                    !(inv_vld && (inv_line == req_line));
            resv_vld_d = 1'b0;
            if (sc_ok) begin
              wr_data_d = alu_new;
              wr_mask_d = lane_mask(op_is_word(req_op), req_addr[2]);
              state_d   = ST_WR_REQ;
            end else begin
              resp_data_d = XLEN'(1);
              state_d     = ST_RESP;
            end
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        if (rd_rdy) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_resp_vld) begin
          resp_data_d = old_ext;
          if (op_is_lr(op_q)) begin
            resv_vld_d  = 1'b1;
            resv_line_d = cur_line;
            state_d     = ST_RESP;
          end else begin
            wr_data_d = alu_new;
            wr_mask_d = lane_mask(op_is_word(op_q), addr_q[2]);
            if (resv_line_q == cur_line) resv_vld_d = 1'b0;
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (wr_rdy) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= STU_NOP;
      addr_q      <= '0;
      data_q      <= '0;
      id_q        <= '0;
      wr_data_q   <= '0;
      wr_mask_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      resv_vld_q  <= 1'b0;
      resv_line_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      id_q        <= id_d;
      wr_data_q   <= wr_data_d;
      wr_mask_q   <= wr_mask_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      resv_vld_q  <= resv_vld_d;
      resv_line_q <= resv_line_d;
    end
  end

  assign req_rdy   = rst_n && (state_q == ST_IDLE);
  assign rd_vld    = (state_q == ST_RD_REQ);
  assign wr_vld    = (state_q == ST_WR_REQ);
  assign resp_vld  = (state_q == ST_RESP);
  assign rd_addr   = {addr_q[PADDR_W-1:3], 3'b000};
  assign wr_addr   = {addr_q[PADDR_W-1:3], 3'b000};
  assign wr_data   = wr_data_q;
  assign wr_mask   = wr_mask_q;
  assign resp_id   = id_q;
  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;

endmodule

// File: tb/tb_l1d_amo_unit.sv
// tb/tb_l1d_amo_unit.sv - directed self-checking bench for l1d_amo_unit
module tb_l1d_amo_unit;
  import uop_encoding_pkg::*;

  localparam int XLEN = 64;
  localparam int PADDR_W = 56;
  localparam int ID_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_vld, req_rdy, rd_vld, rd_rdy, rd_resp_vld, wr_vld, wr_rdy;
  logic resp_vld, resp_rdy, resp_err, inv_vld;
  stu_minor_op_t req_op;
  logic [PADDR_W-1:0] req_addr, rd_addr, wr_addr, inv_addr;
  logic [XLEN-1:0] req_data, rd_resp_data, wr_data, resp_data;
  logic [ID_W-1:0] req_id, resp_id;
  logic [XLEN/8-1:0] wr_mask;

  always #5 clk = ~clk;

  l1d_amo_unit #(.XLEN(XLEN), .PADDR_W(PADDR_W), .ID_W(ID_W), .LINE_OFF_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op), .req_addr(req_addr),
    .req_data(req_data), .req_id(req_id),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_addr(rd_addr),
    .rd_resp_vld(rd_resp_vld), .rd_resp_data(rd_resp_data),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_id(resp_id), .resp_data(resp_data),
    .resp_err(resp_err), .inv_vld(inv_vld), .inv_addr(inv_addr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  logic seen_rd, seen_wr, seen_resp, stable_ok;
  logic [PADDR_W-1:0] o_rd_addr, o_wr_addr;
  logic [XLEN-1:0] o_wr_data, o_resp_data;
  logic [7:0] o_wr_mask;
  logic o_resp_err;
  logic [ID_W-1:0] o_resp_id;

  // Drives one request and plays cache/consumer, stalling write and response by a cycle or two.
  task automatic run_op(input stu_minor_op_t op, input logic [PADDR_W-1:0] addr,
                        input logic [XLEN-1:0] data, input logic [ID_W-1:0] id,
                        input logic [XLEN-1:0] mem, input logic inv_now,
                        input logic [PADDR_W-1:0] inv_a);
    int rd_ph, wr_ph, rs_ph;
    bit done;
    seen_rd = 0; seen_wr = 0; seen_resp = 0; stable_ok = 1;
    rd_ph = 0; wr_ph = 0; rs_ph = 0; done = 0;
    @(negedge clk);
    req_vld = 1; req_op = op; req_addr = addr; req_data = data; req_id = id;
    inv_vld = inv_now; inv_addr = inv_a;
    @(negedge clk);
    req_vld = 0; inv_vld = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (rd_ph == 1) begin rd_resp_vld = 1; rd_resp_data = mem; rd_ph = 2; end
      else if (rd_ph == 2) begin rd_resp_vld = 0; rd_ph = 3; end
      if (rd_vld && rd_ph == 0) begin seen_rd = 1; o_rd_addr = rd_addr; rd_ph = 1; end
      if (wr_vld) begin
        if (wr_ph == 0) begin
          seen_wr = 1; o_wr_addr = wr_addr; o_wr_data = wr_data; o_wr_mask = wr_mask; wr_ph = 1;
        end else if (wr_ph < 3) begin
          if (wr_addr !== o_wr_addr || wr_data !== o_wr_data || wr_mask !== o_wr_mask) stable_ok = 0;
          if (wr_ph == 2) wr_rdy = 1;
          wr_ph++;
        end
      end else if (wr_ph == 3) begin
        wr_rdy = 0; wr_ph = 4;
      end
      if (rs_ph == 2) begin
        resp_rdy = 0; done = 1;
      end else if (resp_vld) begin
        if (rs_ph == 0) begin
          seen_resp = 1; o_resp_data = resp_data; o_resp_err = resp_err; o_resp_id = resp_id; rs_ph = 1;
        end else begin
          if (resp_data !== o_resp_data || resp_err !== o_resp_err || resp_id !== o_resp_id) stable_ok = 0;
          resp_rdy = 1; rs_ph = 2;
        end
      end
      if (!done) @(negedge clk);
    end
    rd_resp_vld = 0; wr_rdy = 0; resp_rdy = 0;
    if (!done) seen_resp = 0;
  endtask

  task automatic expect_op(input string t, input logic exp_rd, input logic [PADDR_W-1:0] exp_rd_addr,
                           input logic exp_wr, input logic [PADDR_W-1:0] exp_wr_addr,
                           input logic [XLEN-1:0] exp_wr_data, input logic [7:0] exp_mask,
                           input logic [XLEN-1:0] exp_resp, input logic exp_err,
                           input logic [ID_W-1:0] exp_id);
    check_eq({t, ".resp_seen"}, seen_resp, 1);
    check_eq({t, ".rd_seen"}, seen_rd, exp_rd);
    check_eq({t, ".wr_seen"}, seen_wr, exp_wr);
    if (exp_rd && seen_rd) check_eq({t, ".rd_addr"}, o_rd_addr, exp_rd_addr);
    if (exp_wr && seen_wr) begin
      check_eq({t, ".wr_addr"}, o_wr_addr, exp_wr_addr);
      check_eq({t, ".wr_data"}, o_wr_data, exp_wr_data);
      check_eq({t, ".wr_mask"}, o_wr_mask, exp_mask);
    end
    if (seen_resp) begin
      check_eq({t, ".resp_data"}, o_resp_data, exp_resp);
      check_eq({t, ".resp_err"}, o_resp_err, exp_err);
      check_eq({t, ".resp_id"}, o_resp_id, exp_id);
    end
    check_eq({t, ".stable"}, stable_ok, 1);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic got, saw;
    req_vld = 0; req_op = STU_NOP; req_addr = '0; req_data = '0; req_id = '0;
    rd_rdy = 1; rd_resp_vld = 0; rd_resp_data = '0; wr_rdy = 0; resp_rdy = 0;
    inv_vld = 0; inv_addr = '0;
    repeat (2) @(negedge clk);
    check_eq("reset.req_rdy", req_rdy, 0);
    check_eq("reset.rd_vld", rd_vld, 0);
    check_eq("reset.wr_vld", wr_vld, 0);
    check_eq("reset.resp_vld", resp_vld, 0);
    check_eq("reset.resp_data", resp_data, 0);
    check_eq("reset.wr_data", wr_data, 0);
    check_eq("reset.rd_addr", rd_addr, 0);
    rst_n = 1;
    @(negedge clk);
    check_eq("idle.req_rdy", req_rdy, 1);

    run_op(STU_AMOADDD, 56'h1000, 64'd7, 4'd3, 64'd5, 0, '0);
    expect_op("addd", 1, 56'h1000, 1, 56'h1000, 64'd12, 8'hFF, 64'd5, 0, 4'd3);

    run_op(STU_AMOMINW, 56'h1004, 64'd1, 4'd4, 64'hFFFF_FFFF_0000_0003, 0, '0);
    expect_op("minw", 1, 56'h1000, 1, 56'h1000, ONES, 8'hF0, ONES, 0, 4'd4);

    run_op(STU_AMOADDW, 56'h5000, 64'd2, 4'd5, 64'h1111_1111_FFFF_FFFF, 0, '0);
    expect_op("addw_lo", 1, 56'h5000, 1, 56'h5000, 64'h0000_0001_0000_0001, 8'h0F, ONES, 0, 4'd5);

    run_op(STU_AMOMAXUD, 56'h5008, ONES, 4'd6, 64'd5, 0, '0);
    expect_op("maxud", 1, 56'h5008, 1, 56'h5008, ONES, 8'hFF, 64'd5, 0, 4'd6);

    run_op(STU_LRD, 56'h2000, 64'd0, 4'd1, 64'h1234, 0, '0);
    expect_op("lrd", 1, 56'h2000, 0, '0, '0, 8'h00, 64'h1234, 0, 4'd1);
    run_op(STU_SCD, 56'h2008, 64'hABCD, 4'd2, 64'd0, 0, '0);
    expect_op("scd_ok", 0, '0, 1, 56'h2008, 64'hABCD, 8'hFF, 64'd0, 0, 4'd2);
    run_op(STU_SCD, 56'h2008, 64'hABCD, 4'd2, 64'd0, 0, '0);
    expect_op("scd_again", 0, '0, 0, '0, '0, 8'h00, 64'd1, 0, 4'd2);

    run_op(STU_LRW, 56'h3000, 64'd0, 4'd8, 64'h0000_0000_8000_0000, 0, '0);
    expect_op("lrw", 1, 56'h3000, 0, '0, '0, 8'h00, 64'hFFFF_FFFF_8000_0000, 0, 4'd8);
    @(negedge clk); inv_vld = 1; inv_addr = 56'h3020;
    @(negedge clk); inv_vld = 0;
    run_op(STU_SCW, 56'h3000, 64'd5, 4'd9, 64'd0, 0, '0);
    expect_op("scw_inv", 0, '0, 0, '0, '0, 8'h00, 64'd1, 0, 4'd9);

    run_op(STU_LRD, 56'h7000, 64'd0, 4'd1, 64'd0, 0, '0);
    run_op(STU_SCD, 56'h7000, 64'd9, 4'd2, 64'd0, 1, 56'h7010);
    expect_op("scd_inv_same", 0, '0, 0, '0, '0, 8'h00, 64'd1, 0, 4'd2);

    run_op(STU_LRD, 56'h8000, 64'd0, 4'd1, 64'd0, 0, '0);
    run_op(STU_AMOXORD, 56'h8008, 64'hFF, 4'd3, 64'hF0, 0, '0);
    expect_op("xord", 1, 56'h8008, 1, 56'h8008, 64'h0F, 8'hFF, 64'hF0, 0, 4'd3);
    run_op(STU_SCD, 56'h8000, 64'd1, 4'd4, 64'd0, 0, '0);
    expect_op("scd_after_amo", 0, '0, 0, '0, '0, 8'h00, 64'd1, 0, 4'd4);

    run_op(STU_LRW, 56'hA004, 64'd0, 4'd5, 64'h0000_0007_0000_0000, 0, '0);
    expect_op("lrw_hi", 1, 56'hA000, 0, '0, '0, 8'h00, 64'd7, 0, 4'd5);
    run_op(STU_SCW, 56'hA004, 64'h1_DEAD_BEEF, 4'd6, 64'd0, 0, '0);
    expect_op("scw_ok", 0, '0, 1, 56'hA000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hF0, 64'd0, 0, 4'd6);

    run_op(STU_AMOSWAPW, 56'h4002, 64'd1, 4'd7, 64'd0, 0, '0);
    expect_op("swapw_misal", 0, '0, 0, '0, '0, 8'h00, 64'd0, 1, 4'd7);
    run_op(STU_LD, 56'h9000, 64'd1, 4'd8, 64'd0, 0, '0);
    expect_op("bad_op", 0, '0, 0, '0, '0, 8'h00, 64'd0, 1, 4'd8);

    @(negedge clk);
    req_vld = 1; req_op = STU_AMOADDD; req_addr = 56'h6100; req_data = 64'd1; req_id = 4'd7;
    @(negedge clk);
    req_vld = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (rd_vld) got = 1;
      else @(negedge clk);
    end
    check_eq("rst.rd_seen", got, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    check_eq("rst.resp_vld", resp_vld, 0);
    check_eq("rst.req_rdy", req_rdy, 0);
    check_eq("rst.rd_vld", rd_vld, 0);
    @(negedge clk);
    rst_n = 1; rd_resp_vld = 1; rd_resp_data = 64'd77;
    @(negedge clk);
    rd_resp_vld = 0;
    saw = 0;
    repeat (4) begin
      if (resp_vld || wr_vld || rd_vld) saw = 1;
      @(negedge clk);
    end
    check_eq("rst.quiet", saw, 0);
    check_eq("rst.req_rdy_after", req_rdy, 1);

    run_op(STU_AMOSWAPD, 56'h6000, 64'd3, 4'd2, 64'd9, 0, '0);
    expect_op("swapd_post_rst", 1, 56'h6000, 1, 56'h6000, 64'd3, 8'hFF, 64'd9, 0, 4'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
